// File: rtl/wb_pkg.sv
// wb_pkg: shared sizes, arbiter states and item type for the register writeback merge.
package wb_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  typedef enum logic {ALU_PRI, DRAIN} arb_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_item_t;
  // Only r1..r15 are writable; r0 and the upper half are silently dropped.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a != '0 && !a[ADDR_W-1];
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load-result queue with per-entry valid bits exposed for pending tracking.
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  wb_item_t              din,
  output wb_item_t              dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      vld_o,
  output logic [DEPTH-1:0][3:0] addr_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  wb_item_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [DEPTH-1:0] vld_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign dout = mem_q[rd_q];
  assign full = &vld_q;
  assign empty = ~|vld_q;
  assign vld_o = vld_q;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) addr_o[i] = mem_q[i].addr[3:0];
  end
  // Push is applied after pop so a same-slot swap at full leaves the entry valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      vld_q <= '0;
    end else begin
      if (pop) begin
        rd_q <= nxt(rd_q);
        vld_q[rd_q] <= 1'b0;
      end
      if (push) begin
        wr_q <= nxt(wr_q);
        vld_q[wr_q] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and queued load results onto the single register-file write port,
// ALU first, with a starve counter forcing a one-cycle load drain.
module reg_writeback #(
  parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH,
  parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       alu_valid,
  input  logic [wb_pkg::ADDR_W-1:0]  alu_waddr,
  input  logic [wb_pkg::DATA_W-1:0]  alu_data,
  output logic                       alu_ready,
  input  logic                       ld_valid,
  input  logic [wb_pkg::ADDR_W-1:0]  ld_waddr,
  input  logic [wb_pkg::DATA_W-1:0]  ld_data,
  output logic                       ld_ready,
  output logic                       write_en,
  output logic [wb_pkg::ADDR_W-1:0]  waddr,
  output logic [wb_pkg::DATA_W-1:0]  data_in,
  output logic [15:0]                pending
);
  import wb_pkg::*;
  arb_state_t state_q, state_d;
  logic [2:0] starve_q, starve_d;
  logic alu_gnt, fifo_gnt, push, full, empty;
  wb_item_t head, ld_item;
  logic [FIFO_DEPTH-1:0] vld;
  logic [FIFO_DEPTH-1:0][3:0] addrs;
  assign alu_ready = state_q == ALU_PRI;
  assign ld_ready = !full;
  assign push = ld_valid && !full && addr_ok(ld_waddr);
  assign ld_item = '{addr: ld_waddr, data: ld_data};
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst(Reset), .push(push), .pop(fifo_gnt), .din(ld_item),
    .dout(head), .full(full), .empty(empty), .vld_o(vld), .addr_o(addrs)
  );
  always_comb begin
    alu_gnt = alu_valid && alu_ready && addr_ok(alu_waddr);
    fifo_gnt = !alu_gnt && !empty;
    starve_d = (alu_gnt && !empty) ? starve_q + 3'd1 : 3'd0;
    state_d = (state_q == ALU_PRI && starve_d == 3'(STARVE_LIMIT)) ? DRAIN : ALU_PRI;
  end
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) if (vld[i]) pending[addrs[i]] = 1'b1;
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ALU_PRI;
      starve_q <= '0;
      write_en <= 1'b0;
      waddr <= '0;
      data_in <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      write_en <= alu_gnt || fifo_gnt;
      if (alu_gnt || fifo_gnt) {waddr, data_in} <= alu_gnt ? {alu_waddr, alu_data} : head;
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scenarios plus random traffic against a queue-based reference model.
module tb_reg_writeback;
  localparam int DEPTH = 4;
  localparam int LIMIT = 4;
  logic CLK = 1'b0, Reset = 1'b1;
  logic alu_valid = 1'b0, ld_valid = 1'b0;
  logic [4:0] alu_waddr = '0, ld_waddr = '0;
  logic [15:0] alu_data = '0, ld_data = '0;
  logic alu_ready, ld_ready, write_en;
  logic [4:0] waddr;
  logic [15:0] data_in, pending;
  int n_chk = 0, n_fail = 0;

  reg_writeback dut (
    .CLK(CLK), .Reset(Reset),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_waddr(ld_waddr), .ld_data(ld_data), .ld_ready(ld_ready),
    .write_en(write_en), .waddr(waddr), .data_in(data_in), .pending(pending)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [4:0] a; logic [15:0] d;} item_t;
  item_t q[$];
  int m_starve;
  bit m_drain, m_we;
  logic [4:0] m_wa;
  logic [15:0] m_wd;

  function automatic bit ok(input logic [4:0] a);
    return a >= 5'd1 && a <= 5'd15;
  endfunction

  function automatic logic [15:0] exp_pend();
    logic [15:0] p = '0;
    foreach (q[i]) p[q[i].a[3:0]] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    q.delete();
    m_starve = 0;
    m_drain = 0;
    m_we = 0;
    m_wa = '0;
    m_wd = '0;
  endtask

  // Advance the reference model by one cycle using the current inputs, then clock the DUT.
  task automatic tick();
    bit ag;
    int sz;
    item_t it;
    sz = q.size();
    ag = !m_drain && alu_valid && ok(alu_waddr);
    m_we = 0;
    if (ag) begin
      m_we = 1; m_wa = alu_waddr; m_wd = alu_data;
    end else if (sz > 0) begin
      it = q.pop_front();
      m_we = 1; m_wa = it.a; m_wd = it.d;
    end
    m_starve = (ag && sz > 0) ? m_starve + 1 : 0;
    m_drain = !m_drain && m_starve == LIMIT;
    if (ld_valid && sz < DEPTH && ok(ld_waddr)) begin
      it.a = ld_waddr; it.d = ld_data;
      q.push_back(it);
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; ld_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    model_clear();
    repeat (2) @(posedge CLK);
    #1 Reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if ({alu_ready, ld_ready, write_en} !== 3'b110)
      begin n_fail++; $display("FAIL reset_flags got=%b exp=110", {alu_ready, ld_ready, write_en}); end
    n_chk++;
    if (pending !== 16'h0 || waddr !== 5'd0 || data_in !== 16'h0)
      begin n_fail++; $display("FAIL reset_regs pending=%h waddr=%0d data=%h exp all 0", pending, waddr, data_in); end
    Reset = 0;
  endtask

  task automatic test_alu_write();
    do_reset();
    alu_valid = 1; alu_waddr = 5'd3; alu_data = 16'h1234;
    tick();
    alu_valid = 0;
    n_chk++;
    if (write_en !== 1'b1 || waddr !== 5'd3 || data_in !== 16'h1234)
      begin n_fail++; $display("FAIL alu_write we=%b waddr=%0d data=%h exp 1/3/1234", write_en, waddr, data_in); end
    tick();
    n_chk++;
    if (write_en !== 1'b0 || waddr !== 5'd3 || data_in !== 16'h1234)
      begin n_fail++; $display("FAIL alu_hold we=%b waddr=%0d data=%h exp 0/3/1234", write_en, waddr, data_in); end
  endtask

  task automatic test_load();
    do_reset();
    ld_valid = 1; ld_waddr = 5'd5; ld_data = 16'hBEEF;
    tick();
    ld_valid = 0;
    n_chk++;
    if (pending !== 16'h0020 || write_en !== 1'b0)
      begin n_fail++; $display("FAIL load_pending pending=%h we=%b exp 0020/0", pending, write_en); end
    tick();
    n_chk++;
    if (write_en !== 1'b1 || waddr !== 5'd5 || data_in !== 16'hBEEF || pending !== 16'h0)
      begin n_fail++; $display("FAIL load_write we=%b waddr=%0d data=%h pending=%h exp 1/5/beef/0", write_en, waddr, data_in, pending); end
  endtask

  task automatic test_drop();
    do_reset();
    alu_valid = 1; alu_waddr = 5'd0; alu_data = 16'h5555;
    ld_valid = 1; ld_waddr = 5'd17; ld_data = 16'hAAAA;
    n_chk++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b1)
      begin n_fail++; $display("FAIL drop_accept alu_ready=%b ld_ready=%b exp 1/1", alu_ready, ld_ready); end
    tick();
    idle_inputs();
    n_chk++;
    if (write_en !== 1'b0 || pending !== 16'h0)
      begin n_fail++; $display("FAIL drop_1 we=%b pending=%h exp 0/0", write_en, pending); end
    tick();
    n_chk++;
    if (write_en !== 1'b0 || pending !== 16'h0)
      begin n_fail++; $display("FAIL drop_2 we=%b pending=%h exp 0/0", write_en, pending); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, first_low = -1, bad = 0;
    logic [4:0] got_a[$];
    logic [15:0] got_d[$];
    do_reset();
    for (int c = 0; c < 28; c++) begin
      alu_valid = 1; alu_waddr = 5'd1; alu_data = 16'(c);
      ld_valid = sent < 5; ld_waddr = 5'(8 + sent); ld_data = 16'(16'hA000 + sent);
      n_chk++;
      if (alu_ready !== !(c > 0 && c % 5 == 0))
        begin n_fail++; $display("FAIL b2b_drain c=%0d alu_ready=%b exp=%b", c, alu_ready, !(c > 0 && c % 5 == 0)); end
      n_chk++;
      if (ld_ready !== (q.size() < DEPTH))
        begin n_fail++; $display("FAIL b2b_ld_ready c=%0d got=%b exp=%b", c, ld_ready, q.size() < DEPTH); end
      if (!ld_ready && first_low < 0) first_low = sent;
      if (ld_valid && q.size() < DEPTH) sent++;
      tick();
      if (write_en !== m_we || waddr !== m_wa || data_in !== m_wd) bad++;
      if (write_en === 1'b1 && waddr !== 5'd1) begin got_a.push_back(waddr); got_d.push_back(data_in); end
    end
    idle_inputs();
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_writes mismatching_cycles=%0d exp 0", bad); end
    n_chk++;
    if (first_low != 4) begin n_fail++; $display("FAIL b2b_full accepted_before_stall=%0d exp 4", first_low); end
    n_chk++;
    if (got_a.size() != 5) begin n_fail++; $display("FAIL b2b_count load_writes=%0d exp 5", got_a.size()); end
    foreach (got_a[i]) begin
      n_chk++;
      if (got_a[i] !== 5'(8 + i) || got_d[i] !== 16'(16'hA000 + i))
        begin n_fail++; $display("FAIL b2b_order i=%0d waddr=%0d data=%h exp %0d/%h", i, got_a[i], got_d[i], 8 + i, 16'hA000 + i); end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_waddr = 5'd2; alu_data = 16'(c);
      ld_valid = 1; ld_waddr = 5'(3 + c); ld_data = 16'(16'hC000 + c);
      tick();
    end
    n_chk++;
    if (pending !== 16'h0038 || write_en !== 1'b1)
      begin n_fail++; $display("FAIL mid_before pending=%h we=%b exp 0038/1", pending, write_en); end
    Reset = 1;
    #1;
    model_clear();
    n_chk++;
    if (pending !== 16'h0 || write_en !== 1'b0 || ld_ready !== 1'b1)
      begin n_fail++; $display("FAIL mid_reset pending=%h we=%b ld_ready=%b exp 0/0/1", pending, write_en, ld_ready); end
    idle_inputs();
    @(posedge CLK); #1 Reset = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (write_en !== 1'b0) seen++;
    end
    n_chk++;
    if (seen != 0) begin n_fail++; $display("FAIL mid_discard writes_after_reset=%0d exp 0", seen); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom % 4) != 0;
      alu_waddr = 5'($urandom_range(0, 19));
      alu_data = 16'($urandom);
      ld_valid = ($urandom % 3) != 0;
      ld_waddr = 5'($urandom_range(0, 19));
      ld_data = 16'($urandom);
      n_chk++;
      if (alu_ready !== !m_drain || ld_ready !== (q.size() < DEPTH) || pending !== exp_pend())
        begin n_fail++; $display("FAIL rnd_comb c=%0d alu_ready=%b ld_ready=%b pending=%h exp %b/%b/%h", c, alu_ready, ld_ready, pending, !m_drain, q.size() < DEPTH, exp_pend()); end
      tick();
      n_chk++;
      if (write_en !== m_we || waddr !== m_wa || data_in !== m_wd)
        begin n_fail++; $display("FAIL rnd_write c=%0d we=%b waddr=%0d data=%h exp %b/%0d/%h", c, write_en, waddr, data_in, m_we, m_wa, m_wd); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
